// File: rtl/sd_init_sequencer.sv
// rtl/sd_init_sequencer.sv - SPI-mode SD card initialisation sequencer
// Drives the SPI comm master through warmup, CMD0, CMD8, CMD55/ACMD41 and CMD58.
module sd_init_sequencer #(
    parameter int WARMUP_CYCLES = 20480,
    parameter int MAX_RETRY     = 255
) (
    input  logic        cpuClock,
    input  logic        nReset,
    input  logic        start,
    input  logic        commFinish,
    input  logic [39:0] readResponse,
    input  logic        errorInterrupt,
    input  logic [3:0]  errorType,
    output logic        commReset,
    output logic        commEnable,
    output logic        spiClockEn,
    output logic        commStart,
    output logic        cmdTransmitBit,
    output logic [5:0]  cmdIndex,
    output logic [31:0] cmdArgument,
    output logic [1:0]  readMode,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [3:0]  failCode,
    output logic [31:0] ocr,
    output logic        isHighCapacity
);

    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST   = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [7:0]        RETRY_LIMIT = 8'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_WARMUP, S_ISSUE, S_WAIT_FIN, S_RELEASE, S_CHECK, S_DONE, S_FAIL
    } state_t;

    typedef enum logic [2:0] {
        STEP_CMD0, STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD58
    } step_t;

    state_t            state, state_d;
    step_t             step, step_d, issue_step;
    logic [WARM_W-1:0] warm, warm_d;
    logic [7:0]        retry, retry_d, retry_inc;
    logic [39:0]       resp, resp_d;
    logic [39:0]       fields_d;
    logic [7:0]        r1;
    logic              do_issue, fail_now;
    logic [3:0]        fcode;
    logic              start_d, done_d, fail_d, hc_d;
    logic [3:0]        code_d;
    logic [31:0]       ocr_d;
    logic              reset_d, enable_d, spiclk_d, busy_d;

    // errorType is consumed by the top level directly while commEnable is held.
    logic unused_error_type;
    assign unused_error_type = ^errorType;

    assign cmdTransmitBit = 1'b1;
    assign retry_inc      = retry + 8'd1;
    assign r1             = (step == STEP_CMD8 || step == STEP_CMD58) ? resp[39:32] : resp[7:0];

    // {readMode, cmdIndex, cmdArgument} for each step
    function automatic logic [39:0] cmd_fields(input step_t s);
        case (s)
            STEP_CMD0:   return {2'b00, 6'd0,  32'h0000_0000};
            STEP_CMD8:   return {2'b10, 6'd8,  32'h0000_01AA};
            STEP_CMD55:  return {2'b00, 6'd55, 32'h0000_0000};
            STEP_ACMD41: return {2'b00, 6'd41, 32'h4000_0000};
            STEP_CMD58:  return {2'b10, 6'd58, 32'h0000_0000};
            default:     return 40'h0;
        endcase
    endfunction

    always_comb begin
        state_d    = state;
        step_d     = step;
        warm_d     = warm;
        retry_d    = retry;
        resp_d     = resp;
        fields_d   = {readMode, cmdIndex, cmdArgument};
        start_d    = commStart;
        done_d     = done;
        fail_d     = fail;
        code_d     = failCode;
        ocr_d      = ocr;
        hc_d       = isHighCapacity;
        issue_step = step;
        do_issue   = 1'b0;
        fail_now   = 1'b0;
        fcode      = 4'd0;

        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d = S_WARMUP;
                    warm_d  = '0;
                    step_d  = STEP_CMD0;
                    retry_d = 8'd0;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    code_d  = 4'd0;
                    ocr_d   = 32'h0;
                    hc_d    = 1'b0;
                end
            end
            S_WARMUP: begin
                if (warm == WARM_LAST) do_issue = 1'b1;
                else                   warm_d   = warm + WARM_W'(1);
            end
            S_ISSUE: begin
                if (errorInterrupt) begin fail_now = 1'b1; fcode = 4'd1; end
                else                state_d = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                if (errorInterrupt) begin
                    fail_now = 1'b1;
                    fcode    = 4'd1;
                end else if (commFinish) begin
                    resp_d  = readResponse;
                    start_d = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Hold off until the master leaves FINISH so it never sees a stale start.
                if (errorInterrupt)   begin fail_now = 1'b1; fcode = 4'd1; end
                else if (!commFinish) state_d = S_CHECK;
            end
            S_CHECK: begin
                case (step)
                    STEP_CMD0: begin
                        if (r1 == 8'h01) begin do_issue = 1'b1; issue_step = STEP_CMD8; end
                        else             begin fail_now = 1'b1; fcode = 4'd2; end
                    end
                    STEP_CMD8: begin
                        if (r1 == 8'h01 && resp[11:0] == 12'h1AA) begin
                            do_issue = 1'b1; issue_step = STEP_CMD55;
                        end else begin
                            fail_now = 1'b1; fcode = 4'd3;
                        end
                    end
                    STEP_CMD55: begin
                        if (r1 == 8'h00 || r1 == 8'h01) begin do_issue = 1'b1; issue_step = STEP_ACMD41; end
                        else                            begin fail_now = 1'b1; fcode = 4'd5; end
                    end
                    STEP_ACMD41: begin
                        if (r1 == 8'h00) begin
                            do_issue = 1'b1; issue_step = STEP_CMD58;
                        end else if (r1 == 8'h01) begin
                            retry_d = retry_inc;
                            if (retry_inc == RETRY_LIMIT) begin fail_now = 1'b1; fcode = 4'd4; end
                            else                          begin do_issue = 1'b1; issue_step = STEP_CMD55; end
                        end else begin
                            fail_now = 1'b1; fcode = 4'd4;
                        end
                    end
                    STEP_CMD58: begin
                        if (r1 != 8'h00)    begin fail_now = 1'b1; fcode = 4'd6; end
                        else if (!resp[31]) begin fail_now = 1'b1; fcode = 4'd7; end
                        else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            ocr_d   = resp[31:0];
                            hc_d    = resp[30];
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        if (do_issue) begin
            state_d  = S_ISSUE;
            step_d   = issue_step;
            fields_d = cmd_fields(issue_step);
            start_d  = 1'b1;
        end
        if (fail_now) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
            code_d  = fcode;
            start_d = 1'b0;
        end

        reset_d  = (state_d == S_IDLE) || (state_d == S_FAIL);
        enable_d = (state_d != S_IDLE);
        spiclk_d = !((state_d == S_IDLE) || (state_d == S_FAIL));
        busy_d   = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_FAIL));
    end

    always_ff @(posedge cpuClock or negedge nReset) begin
        if (!nReset) begin
            state          <= S_IDLE;
            step           <= STEP_CMD0;
            warm           <= '0;
            retry          <= 8'd0;
            resp           <= 40'h0;
            commReset      <= 1'b1;
            commEnable     <= 1'b0;
            spiClockEn     <= 1'b0;
            commStart      <= 1'b0;
            cmdIndex       <= 6'd0;
            cmdArgument    <= 32'h0;
            readMode       <= 2'b00;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            failCode       <= 4'd0;
            ocr            <= 32'h0;
            isHighCapacity <= 1'b0;
        end else begin
            state          <= state_d;
            step           <= step_d;
            warm           <= warm_d;
            retry          <= retry_d;
            resp           <= resp_d;
            commReset      <= reset_d;
            commEnable     <= enable_d;
            spiClockEn     <= spiclk_d;
            commStart      <= start_d;
            readMode       <= fields_d[39:38];
            cmdIndex       <= fields_d[37:32];
            cmdArgument    <= fields_d[31:0];
            busy           <= busy_d;
            done           <= done_d;
            fail           <= fail_d;
            failCode       <= code_d;
            ocr            <= ocr_d;
            isHighCapacity <= hc_d;
        end
    end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// tb/tb_sd_init_sequencer.sv - self-checking bench for sd_init_sequencer
module tb_sd_init_sequencer;

    localparam int WARM    = 16;
    localparam int RETRIES = 4;

    logic        cpuClock = 1'b0;
    logic        nReset = 1'b0;
    logic        start = 1'b0;
    logic        commFinish = 1'b0;
    logic [39:0] readResponse = 40'h0;
    logic        errorInterrupt = 1'b0;
    logic [3:0]  errorType = 4'h0;
    logic        commReset, commEnable, spiClockEn, commStart, cmdTransmitBit;
    logic [5:0]  cmdIndex;
    logic [31:0] cmdArgument;
    logic [1:0]  readMode;
    logic        busy, done, fail;
    logic [3:0]  failCode;
    logic [31:0] ocr;
    logic        isHighCapacity;

    sd_init_sequencer #(.WARMUP_CYCLES(WARM), .MAX_RETRY(RETRIES)) dut (
        .cpuClock(cpuClock), .nReset(nReset), .start(start),
        .commFinish(commFinish), .readResponse(readResponse),
        .errorInterrupt(errorInterrupt), .errorType(errorType),
        .commReset(commReset), .commEnable(commEnable), .spiClockEn(spiClockEn),
        .commStart(commStart), .cmdTransmitBit(cmdTransmitBit), .cmdIndex(cmdIndex),
        .cmdArgument(cmdArgument), .readMode(readMode), .busy(busy), .done(done),
        .fail(fail), .failCode(failCode), .ocr(ocr), .isHighCapacity(isHighCapacity)
    );

    always #5 cpuClock = ~cpuClock;

    int nvec = 0;
    int nbad = 0;

    // scenario: card responses
    logic [39:0] cfg_cmd8, cfg_cmd58;
    int          cfg_a41_busy;
    bit          cfg_err55;

    // transaction-level model of the init flow
    logic [5:0]  exp_next;
    int          exp_outcome;      // 0 running, 1 done, 2 fail
    logic [3:0]  exp_code;
    logic [31:0] exp_ocr;
    int          model_retry;

    bit          in_seq, finished, counting_warm, err_chk, rsp_busy, prev_cs;
    int          warm_cnt, rsp_delay, a41_cnt;
    logic [5:0]  cur_cmd;
    int          n_issued[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_arg(input logic [5:0] idx);
        if (idx == 6'd8)  return 32'h0000_01AA;
        if (idx == 6'd41) return 32'h4000_0000;
        return 32'h0;
    endfunction

    function automatic logic [1:0] exp_mode(input logic [5:0] idx);
        return (idx == 6'd8 || idx == 6'd58) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [39:0] resp_for(input logic [5:0] idx);
        case (idx)
            6'd8:    return cfg_cmd8;
            6'd41:   return (a41_cnt <= cfg_a41_busy) ? 40'h01 : 40'h00;
            6'd58:   return cfg_cmd58;
            default: return 40'h01;
        endcase
    endfunction

    function automatic void model_fail(input logic [3:0] c);
        exp_outcome = 2;
        exp_code    = c;
    endfunction

    function automatic void model_apply(input logic [5:0] idx, input logic [39:0] rsp, input bit err);
        logic [7:0]  r1;
        logic [31:0] pl;
        r1 = (exp_mode(idx) == 2'b10) ? rsp[39:32] : rsp[7:0];
        pl = rsp[31:0];
        if (err) model_fail(4'd1);
        else case (idx)
            6'd0:  if (r1 == 8'h01) exp_next = 6'd8; else model_fail(4'd2);
            6'd8:  if (r1 == 8'h01 && pl[11:0] == 12'h1AA) exp_next = 6'd55; else model_fail(4'd3);
            6'd55: if (r1 == 8'h00 || r1 == 8'h01) exp_next = 6'd41; else model_fail(4'd5);
            6'd41: begin
                if (r1 == 8'h00) exp_next = 6'd58;
                else if (r1 == 8'h01) begin
                    model_retry++;
                    if (model_retry == RETRIES) model_fail(4'd4); else exp_next = 6'd55;
                end else model_fail(4'd4);
            end
            6'd58: begin
                if (r1 != 8'h00)  model_fail(4'd6);
                else if (!pl[31]) model_fail(4'd7);
                else begin exp_outcome = 1; exp_ocr = pl; end
            end
            default: model_fail(4'd15);
        endcase
    endfunction

    // One cycle: sample at negedge, compare against the model, then play comm master.
    task automatic tick();
        @(negedge cpuClock);
        if (!nReset) begin
            commFinish = 1'b0; errorInterrupt = 1'b0; readResponse = 40'h0;
            rsp_busy = 0; prev_cs = 0; in_seq = 0; counting_warm = 0; err_chk = 0;
            return;
        end
        check("tx_bit", 64'(cmdTransmitBit), 64'(1));
        check("spiclk_level", 64'(spiClockEn), 64'(busy | done));
        check("reset_level", 64'(commReset), 64'(!(busy | done)));
        check("enable_level", 64'(commEnable), 64'(busy | done | fail));
        check("done_fail_excl", 64'(done & fail), 64'(0));
        if (start && !in_seq) begin
            in_seq = 1; finished = 0; counting_warm = 1; warm_cnt = 0;
            exp_next = 6'd0; exp_outcome = 0; exp_code = 4'd0; exp_ocr = 32'h0;
            model_retry = 0; a41_cnt = 0; n_issued = '{default: 0};
            check("restart_busy", 64'(busy), 64'(1));
            check("restart_clear", 64'({done, fail, failCode, ocr, isHighCapacity}), 64'(0));
        end
        if (counting_warm) begin
            if (commStart) begin
                check("warmup_len", 64'(warm_cnt), 64'(WARM));
                counting_warm = 0;
            end else if (busy) warm_cnt++;
        end
        if (err_chk) begin
            check("err_start_drop", 64'(commStart), 64'(0));
            err_chk = 0;
        end
        if (in_seq && (done || fail)) begin
            check("out_done", 64'(done), 64'(exp_outcome == 1));
            check("out_fail", 64'(fail), 64'(exp_outcome == 2));
            check("out_code", 64'(failCode), 64'(exp_code));
            check("out_ocr", 64'(ocr), 64'(exp_ocr));
            check("out_hc", 64'(isHighCapacity), 64'(exp_ocr[30]));
            in_seq = 0; finished = 1;
        end
        if (commStart && !prev_cs) begin
            check("issue_live", 64'(exp_outcome), 64'(0));
            check("cmd_index", 64'(cmdIndex), 64'(exp_next));
            check("cmd_arg", 64'(cmdArgument), 64'(exp_arg(exp_next)));
            check("read_mode", 64'(readMode), 64'(exp_mode(exp_next)));
            cur_cmd = cmdIndex;
            n_issued[cur_cmd]++;
            if (cur_cmd == 6'd41) a41_cnt++;
            rsp_busy = 1; rsp_delay = 3;
        end else if (commStart && rsp_busy && !commFinish) begin
            check("field_hold", 64'({cmdIndex, cmdArgument}), 64'({cur_cmd, exp_arg(cur_cmd)}));
            rsp_delay--;
            if (rsp_delay == 0) begin
                readResponse   = resp_for(cur_cmd);
                commFinish     = 1'b1;
                errorInterrupt = cfg_err55 && (cur_cmd == 6'd55);
                if (errorInterrupt) err_chk = 1;
                model_apply(cur_cmd, readResponse, errorInterrupt);
            end
        end else if (commFinish && !commStart) begin
            commFinish = 1'b0; errorInterrupt = 1'b0; rsp_busy = 0;
        end
        prev_cs = commStart;
    endtask

    task automatic run_seq();
        in_seq = 0; finished = 0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && !finished; i++) tick();
        check("seq_complete", 64'(finished), 64'(1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_levels"}, 64'({commReset, commEnable, spiClockEn, commStart, cmdTransmitBit}), 64'(5'b10001));
        check({tag, "_fields"}, 64'({cmdIndex, cmdArgument, readMode}), 64'(0));
        check({tag, "_status"}, 64'({busy, done, fail, failCode, isHighCapacity}), 64'(0));
        check({tag, "_ocr"}, 64'(ocr), 64'(0));
    endtask

    initial begin
        cfg_cmd8 = 40'h01_0000_01AA; cfg_cmd58 = 40'h00_C0FF_8000;
        cfg_a41_busy = 2; cfg_err55 = 0;
        tick();
        check_reset_values("por");
        nReset = 1'b1;
        tick();

        // nominal SDHC card, two busy ACMD41 replies
        run_seq();
        check("nom_done", 64'(done), 64'(1));
        check("nom_cmd55_count", 64'(n_issued[55]), 64'(3));
        check("nom_ocr", 64'(ocr), 64'h0000_0000_C0FF_8000);
        check("nom_hc_code", 64'({isHighCapacity, failCode}), 64'(5'b10000));

        // CMD8 echo mismatch
        cfg_cmd8 = 40'h01_0000_01AB;
        run_seq();
        check("cmd8_code", 64'(failCode), 64'(3));
        check("cmd8_levels", 64'({fail, commReset, spiClockEn}), 64'(3'b110));
        check("cmd8_no_cmd55", 64'(n_issued[55]), 64'(0));

        // ACMD41 never leaves idle
        cfg_cmd8 = 40'h01_0000_01AA; cfg_a41_busy = 1000;
        run_seq();
        check("timeout_acmd41_count", 64'(n_issued[41]), 64'(RETRIES));
        check("timeout_code", 64'(failCode), 64'(4));

        // comm error together with commFinish on CMD55
        cfg_a41_busy = 2; cfg_err55 = 1;
        run_seq();
        check("err_code", 64'(failCode), 64'(1));
        check("err_no_acmd41", 64'(n_issued[41]), 64'(0));
        cfg_err55 = 0;

        // reset while waiting for CMD8's response
        in_seq = 0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && n_issued[8] == 0; i++) tick();
        check("cmd8_reached", 64'(n_issued[8]), 64'(1));
        tick();
        #3 nReset = 1'b0;
        #1 check_reset_values("midop");
        tick();
        tick();
        nReset = 1'b1;
        tick();
        run_seq();
        check("rerun_done", 64'(done), 64'(1));
        check("rerun_cmd0_once", 64'(n_issued[0]), 64'(1));
        check("rerun_ocr", 64'(ocr), 64'h0000_0000_C0FF_8000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
